fft_ctrl: RTL and testbench
===========================

# fft_ctrl

Sequencer for the single-precision radix-2 butterfly unit. It runs an in-place, decimation-in-time FFT of N = 2^LOG2N points held in an external dual-port sample memory. For each stage and butterfly it generates the read addresses, the twiddle-ROM index, the butterfly start pulse and the write-back strobe. The block sits between the top-level FFT start/done handshake and the butterfly/memory datapath, and never touches sample data itself.

## Interface
Parameters:
- LOG2N, default 3: log2 of transform size; legal range 2..10.
- BF_TIMEOUT, default 64: maximum cycles to wait for bf_done; used only when FFT_CTRL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transform; ignored while busy.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the transform completes.
- rd_en  out  1  memory read strobe, both ports.
- addr_a  out  LOG2N  upper-leg address, used for read and write.
- addr_b  out  LOG2N  lower-leg address, used for read and write.
- tw_addr  out  LOG2N-1  twiddle ROM index.
- bf_str  out  1  one-cycle start pulse to the butterfly (its str_sig).
- bf_done  in  1  butterfly completion (its done_sig).
- wr_en  out  1  write strobe; writes y0 to addr_a and y1 to addr_b.
- err  out  1  timeout flag; present only with FFT_CTRL_TIMEOUT_EN.

## Operation
- States: IDLE, READ, WAIT_RD, START, WAIT_BF, WRITE, DONE.
- Counters: stage s (0..LOG2N-1) and butterfly k (0..N/2-1). Both clear on start.
- Address rules, all unsigned with LOG2N-bit truncation:
  - span = 1<<s
  - pos = k & (span-1)
  - grp = k >> s
  - addr_a = (grp<<(s+1)) + pos
  - addr_b = addr_a + span
  - tw_addr = pos << (LOG2N-1-s)
- addr_a, addr_b and tw_addr are registered and update only on entry to READ. They hold through WRITE.
- State transitions:
  - IDLE→READ on start.
  - READ→WAIT_RD.
  - WAIT_RD→START.
  - START→WAIT_BF.
  - WAIT_BF→WRITE on the first cycle bf_done is sampled high.
  - In WRITE: if k = N/2-1, k wraps to 0 and s increments. If s = LOG2N-1 and k = N/2-1, next state is DONE; otherwise next state is READ.
  - DONE→IDLE.
- Strobes: rd_en is high only in READ, bf_str only in START, wr_en only in WRITE, done only in DONE.
- bf_done is ignored outside WAIT_BF.
- start is ignored outside IDLE, including a start that coincides with DONE.
- Memory contract: synchronous read with one-cycle latency, and read data held stable until the next rd_en. This keeps butterfly operands valid through WAIT_BF.
- Input samples must already be in bit-reversed order in memory. Output is in natural order.

## Timing
- Reset values: busy, done, rd_en, bf_str and wr_en are 0. addr_a, addr_b, tw_addr, s, k and err are 0. State is IDLE.
- rst asserted in any state forces the reset values on the next edge and abandons the transform. No partial write occurs after reset.
- start sampled high in IDLE: READ occurs the next cycle.
- Per-butterfly time is D+4 cycles, where bf_done is sampled high D cycles after the START cycle (D ≥ 1).
- Total time from start to done = 1 + (LOG2N·N/2)·(D+4) cycles.
- Back-to-back operation: a start in the cycle after DONE (state IDLE) is accepted.

## Configuration
- Macro FFT_CTRL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_BF.
  - If bf_done has not arrived after BF_TIMEOUT cycles, the FSM enters IDLE without asserting wr_en or done, and err goes high.
  - err stays high until the next accepted start or rst.
- Undefined:
  - No err port and no counter; WAIT_BF waits indefinitely.

## Test plan
- LOG2N=3, bf_done model with D=5, one start: (addr_a, addr_b, tw_addr) must follow this sequence, then a single done pulse:
  - Stage 0: (0,1,0), (2,3,0), (4,5,0), (6,7,0)
  - Stage 1: (0,2,0), (1,3,2), (4,6,0), (5,7,2)
  - Stage 2: (0,4,0), (1,5,1), (2,6,2), (3,7,3)
- Same setup: done goes high exactly 109 cycles after the start cycle, and wr_en pulses 12 times.
- start re-pulsed mid-transform, plus spurious bf_done pulses in READ and WRITE: the address sequence and pulse counts are unchanged.
- rst asserted during WAIT_BF of stage 1, k=2: all outputs are 0 the next cycle. A fresh start then restarts at (0,1,0).
- With FFT_CTRL_TIMEOUT_EN and BF_TIMEOUT=16, bf_done held low: err rises and the FSM returns to IDLE after 16 WAIT_BF cycles, with no wr_en and no done. A following start clears err.
- Golden check with the real butterfly and RAM: LOG2N=2, input {1,1,1,1} (pre-bitreversed) produces output {4,0,0,0}, imaginary parts 0.

Source files
------------

// File: rtl/fft_ctrl_if.sv
// Handshake and memory/butterfly control bundle for fft_ctrl.
// err is present only when FFT_CTRL_TIMEOUT_EN is defined.
interface fft_ctrl_if #(
   parameter int LOG2N = 3
);
   logic             start;
   logic             busy;
   logic             done;
   logic             rd_en;
   logic [LOG2N-1:0] addr_a;
   logic [LOG2N-1:0] addr_b;
   logic [LOG2N-2:0] tw_addr;
   logic             bf_str;
   logic             bf_done;
   logic             wr_en;
`ifdef FFT_CTRL_TIMEOUT_EN
   logic             err;
`endif

   modport master (
      input  start, bf_done,
      output busy, done, rd_en, addr_a, addr_b, tw_addr, bf_str, wr_en
`ifdef FFT_CTRL_TIMEOUT_EN
      , output err
`endif
   );

   modport slave (
      output start, bf_done,
      input  busy, done, rd_en, addr_a, addr_b, tw_addr, bf_str, wr_en
`ifdef FFT_CTRL_TIMEOUT_EN
      , input err
`endif
   );
endinterface

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: addresses, twiddle index and strobes per butterfly.
// Optional butterfly timeout with err flag under macro FFT_CTRL_TIMEOUT_EN.
module fft_ctrl #(
   parameter int LOG2N      = 3,
   parameter int BF_TIMEOUT = 64
) (
   input logic       clk,
   input logic       rst,
   fft_ctrl_if.master bus
);
   localparam int NB  = 1 << (LOG2N - 1);
   localparam int SW  = $clog2(LOG2N + 1);
   localparam int KW  = LOG2N - 1;
   localparam int TWW = LOG2N - 1;
   localparam logic [LOG2N-1:0] ONE = 1;

   typedef enum logic [2:0] {
      IDLE, READ, WAIT_RD, START, WAIT_BF, WRITE, DONE
   } state_t;

   state_t           state_q, state_d;
   logic [SW-1:0]    s_q, s_d;
   logic [KW-1:0]    k_q, k_d;
   logic [LOG2N-1:0] addr_a_q, addr_a_d;
   logic [LOG2N-1:0] addr_b_q, addr_b_d;
   logic [TWW-1:0]   tw_q, tw_d;
   logic [LOG2N-1:0] kx, span, pos, grp, a_new;
   logic             last_k, last_s;

`ifdef FFT_CTRL_TIMEOUT_EN
   localparam int TOW = $clog2(BF_TIMEOUT + 1);
   logic [TOW-1:0]   to_q, to_d;
   logic             err_q, err_d;
`endif

   assign last_k = (k_q == KW'(NB - 1));
   assign last_s = (s_q == SW'(LOG2N - 1));

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      k_d      = k_q;
      addr_a_d = addr_a_q;
      addr_b_d = addr_b_q;
      tw_d     = tw_q;
`ifdef FFT_CTRL_TIMEOUT_EN
      to_d     = to_q;
      err_d    = err_q;
`endif
      unique case (state_q)
         IDLE: if (bus.start) begin
            state_d = READ;
            s_d     = '0;
            k_d     = '0;
`ifdef FFT_CTRL_TIMEOUT_EN
            err_d   = 1'b0;
`endif
         end
         READ:    state_d = WAIT_RD;
         WAIT_RD: state_d = START;
         START: begin
            state_d = WAIT_BF;
`ifdef FFT_CTRL_TIMEOUT_EN
            to_d    = '0;
`endif
         end
         WAIT_BF: begin
            if (bus.bf_done) begin
               state_d = WRITE;
`ifdef FFT_CTRL_TIMEOUT_EN
            end else if (to_q == TOW'(BF_TIMEOUT - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               to_d    = to_q + TOW'(1);
`endif
            end
         end
         WRITE: begin
            if (last_k) begin
               k_d = '0;
               s_d = s_q + SW'(1);
            end else begin
               k_d = k_q + KW'(1);
            end
            state_d = (last_k && last_s) ? DONE : READ;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Addresses come from the next-cycle counters so they are ready in READ.
      kx    = {1'b0, k_d};
      span  = ONE << s_d;
      pos   = kx & (span - ONE);
      grp   = kx >> s_d;
      a_new = (grp << (s_d + SW'(1))) + pos;
      if (state_d == READ) begin
         addr_a_d = a_new;
         addr_b_d = a_new + span;
         tw_d     = TWW'(pos << (LOG2N - 1 - int'(s_d)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         s_q      <= '0;
         k_q      <= '0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         tw_q     <= '0;
`ifdef FFT_CTRL_TIMEOUT_EN
         to_q     <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         k_q      <= k_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         tw_q     <= tw_d;
`ifdef FFT_CTRL_TIMEOUT_EN
         to_q     <= to_d;
         err_q    <= err_d;
`endif
      end
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == DONE);
   assign bus.rd_en   = (state_q == READ);
   assign bus.bf_str  = (state_q == START);
   assign bus.wr_en   = (state_q == WRITE);
   assign bus.addr_a  = addr_a_q;
   assign bus.addr_b  = addr_b_q;
   assign bus.tw_addr = tw_q;
`ifdef FFT_CTRL_TIMEOUT_EN
   assign bus.err     = err_q;
`endif
endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl: address sequence, pulse counts, latency, reset, timeout
// and an integer butterfly/RAM model for a 4-point golden transform.
module tb_fft_ctrl;
   localparam int D = 5;

   logic clk;
   logic rst;
   int   cyc;
   int   n_vec, n_err;

   fft_ctrl_if #(.LOG2N(3)) u_if ();
   fft_ctrl_if #(.LOG2N(2)) u_if2 ();

   fft_ctrl #(.LOG2N(3), .BF_TIMEOUT(16)) u_dut (.clk(clk), .rst(rst), .bus(u_if));
   fft_ctrl #(.LOG2N(2), .BF_TIMEOUT(16)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int a; int b; int tw;} exp_t;
   exp_t q[$];
   exp_t cur;
   int tab8[12][3] = '{
      '{0,1,0}, '{2,3,0}, '{4,5,0}, '{6,7,0},
      '{0,2,0}, '{1,3,2}, '{4,6,0}, '{5,7,2},
      '{0,4,0}, '{1,5,1}, '{2,6,2}, '{3,7,3}};

   int rd_cnt, wr_cnt, done_cnt;
   int start_cyc, lat;
   bit spur, hold_low;
   int fire;

   int re[4], im[4];
   int ar, ai, br, bi, wr, wi;
   bit pend2;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_table();
      for (int i = 0; i < 12; i++) q.push_back('{tab8[i][0], tab8[i][1], tab8[i][2]});
   endtask

   task automatic clear_counts();
      rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
   endtask

   task automatic pulse_start();
      u_if.start = 1'b1;
      start_cyc  = cyc;
      tick();
      u_if.start = 1'b0;
   endtask

   task automatic run_to_done(output int l);
      int n;
      n = 0;
      while (!u_if.done && n < 3000) begin
         tick();
         n++;
      end
      if (!u_if.done) check("done_timeout", 0, 1);
      l = cyc - start_cyc;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},   u_if.busy,    0);
      check({tag, "_done"},   u_if.done,    0);
      check({tag, "_rd_en"},  u_if.rd_en,   0);
      check({tag, "_bf_str"}, u_if.bf_str,  0);
      check({tag, "_wr_en"},  u_if.wr_en,   0);
      check({tag, "_addr_a"}, u_if.addr_a,  0);
      check({tag, "_addr_b"}, u_if.addr_b,  0);
      check({tag, "_tw"},     u_if.tw_addr, 0);
   endtask

   // Scoreboard monitor: expected triple popped on each read, re-checked at write-back.
   initial begin
      cur = '{-1, -1, -1};
      forever begin
         @(negedge clk);
         if (u_if.rd_en) begin
            rd_cnt++;
            if (q.size() == 0) check("rd_extra", 1, 0);
            else begin
               cur = q.pop_front();
               check("rd_addr_a", u_if.addr_a, cur.a);
               check("rd_addr_b", u_if.addr_b, cur.b);
               check("rd_tw",     u_if.tw_addr, cur.tw);
            end
         end
         if (u_if.wr_en) begin
            wr_cnt++;
            check("wr_addr_a", u_if.addr_a, cur.a);
            check("wr_addr_b", u_if.addr_b, cur.b);
            check("wr_tw",     u_if.tw_addr, cur.tw);
         end
         if (u_if.done) done_cnt++;
      end
   end

   // Butterfly model: done D cycles after the start pulse, plus optional spurious pulses.
   initial begin
      u_if.bf_done = 1'b0;
      fire = -1;
      forever begin
         @(negedge clk);
         u_if.bf_done = !hold_low && ((cyc == fire) || (spur && (u_if.rd_en || u_if.wr_en)));
         if (u_if.bf_str) fire = cyc + D;
      end
   end

   // 4-point RAM + integer butterfly (W^0 = 1, W^1 = -j), one-cycle bf latency.
   initial begin
      u_if2.bf_done = 1'b0;
      pend2 = 1'b0;
      forever begin
         @(negedge clk);
         u_if2.bf_done = pend2;
         pend2 = u_if2.bf_str;
         if (u_if2.rd_en) begin
            ar = re[u_if2.addr_a]; ai = im[u_if2.addr_a];
            br = re[u_if2.addr_b]; bi = im[u_if2.addr_b];
         end
         if (u_if2.wr_en) begin
            if (u_if2.tw_addr == 1'b0) begin wr = br; wi = bi; end
            else begin wr = bi; wi = -br; end
            re[u_if2.addr_a] = ar + wr; im[u_if2.addr_a] = ai + wi;
            re[u_if2.addr_b] = ar - wr; im[u_if2.addr_b] = ai - wi;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got running, expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, bs_cyc;
      n_vec = 0; n_err = 0;
      rst = 1'b1; u_if.start = 1'b0; u_if2.start = 1'b0;
      spur = 0; hold_low = 0;
      clear_counts();
      for (int i = 0; i < 4; i++) begin re[i] = 1; im[i] = 0; end
      repeat (3) tick();
      check_idle_outputs("rst");
`ifdef FFT_CTRL_TIMEOUT_EN
      check("rst_err", u_if.err, 0);
`endif
      rst = 1'b0;
      tick();

      // Plain transform
      push_table(); clear_counts();
      pulse_start();
      check("busy_run", u_if.busy, 1);
      run_to_done(lat);
      check("latency", lat, 109);
      tick(); tick();
      check("wr_count", wr_cnt, 12);
      check("done_count", done_cnt, 1);
      check("q_empty", q.size(), 0);
      check("busy_after", u_if.busy, 0);

      // Restart request mid-run and spurious bf_done in READ/WRITE
      push_table(); clear_counts(); spur = 1;
      pulse_start();
      repeat (20) tick();
      u_if.start = 1'b1; tick(); u_if.start = 1'b0;
      run_to_done(lat);
      check("latency_spur", lat, 109);
      check("wr_count_spur", wr_cnt, 12);
      check("q_empty_spur", q.size(), 0);
      // start held over DONE (ignored) and the following IDLE cycle (accepted)
      push_table();
      u_if.start = 1'b1;
      tick();
      clear_counts();
      start_cyc = cyc;
      tick();
      u_if.start = 1'b0;
      run_to_done(lat);
      check("latency_b2b", lat, 109);
      tick(); tick();
      check("wr_count_b2b", wr_cnt, 12);
      check("done_count_b2b", done_cnt, 1);
      spur = 0;

      // Reset during WAIT_BF of stage 1, k = 2
      push_table(); clear_counts();
      pulse_start();
      n = 0;
      while (rd_cnt < 7 && n < 500) begin tick(); n++; end
      n = 0;
      while (!u_if.bf_str && n < 50) begin tick(); n++; end
      check("reach_start", u_if.bf_str, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_outputs("mid_rst");
      q.delete();
      repeat (20) tick();
      check("wr_after_rst", wr_cnt, 6);
      check("done_after_rst", done_cnt, 0);
      push_table(); clear_counts();
      pulse_start();
      run_to_done(lat);
      check("latency_post_rst", lat, 109);
      tick(); tick();
      check("wr_count_post_rst", wr_cnt, 12);

`ifdef FFT_CTRL_TIMEOUT_EN
      // Butterfly never answers
      hold_low = 1; clear_counts();
      q.push_back('{0, 1, 0});
      pulse_start();
      n = 0;
      while (!u_if.bf_str && n < 50) begin tick(); n++; end
      bs_cyc = cyc;
      n = 0;
      while (!u_if.err && n < 100) begin tick(); n++; end
      check("err_rise", u_if.err, 1);
      check("timeout_cycles", cyc - bs_cyc, 17);
      check("timeout_busy", u_if.busy, 0);
      repeat (5) tick();
      check("timeout_wr", wr_cnt, 0);
      check("timeout_done", done_cnt, 0);
      check("err_hold", u_if.err, 1);
      hold_low = 0;
      push_table(); clear_counts();
      pulse_start();
      check("err_clear", u_if.err, 0);
      run_to_done(lat);
      check("latency_after_to", lat, 109);
      tick(); tick();
`else
      bs_cyc = 0;
`endif

      // Golden 4-point transform of {1,1,1,1}
      u_if2.start = 1'b1; tick(); u_if2.start = 1'b0;
      n = 0;
      while (!u_if2.done && n < 200) begin tick(); n++; end
      check("gold_done", u_if2.done, 1);
      check("gold_re0", re[0], 4);
      check("gold_re1", re[1], 0);
      check("gold_re2", re[2], 0);
      check("gold_re3", re[3], 0);
      for (int i = 0; i < 4; i++) check("gold_im", im[i], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
